// File: rtl/lq_agen_csel_pipe_if.sv
// lq_agen_csel_pipe_if: issue-side operands and ex4 carry results of the AGEN carry-select pipe.
// Byte i of the architectural numbering ([0]=MSB byte) sits at vector bit NGRP-1-i.
interface lq_agen_csel_pipe_if #(
  parameter int unsigned NGRP = 8
);
  logic            ex2_vld;
  logic [NGRP-1:0] ex2_g08;
  logic [NGRP-1:0] ex2_t08;
  logic            ex2_ci;
  logic            ex2_mode32;
  logic            stall;
  logic            flush;
  logic            ex4_vld;
  logic [NGRP-1:0] ex4_cin;
  logic            ex4_cout;
  logic            chk_err;

  modport master (
    output ex2_vld, ex2_g08, ex2_t08, ex2_ci, ex2_mode32, stall, flush,
    input  ex4_vld, ex4_cin, ex4_cout, chk_err
  );

  modport slave (
    input  ex2_vld, ex2_g08, ex2_t08, ex2_ci, ex2_mode32, stall, flush,
    output ex4_vld, ex4_cin, ex4_cout, chk_err
  );
endinterface

// File: rtl/lq_agen_csel_pipe.sv
// lq_agen_csel_pipe: resolves byte-group g/t lookahead into per-byte carry-ins and carry-out (ex2->ex3->ex4).
// Optional serial ripple cross-check enabled by defining LQ_AGEN_CSEL_RIPPLE_CHK_EN.
module lq_agen_csel_pipe #(
  parameter int unsigned NGRP    = 8,
  parameter bit          RST_VAL = 1'b0
) (
  input logic                clk,
  input logic                rst,
  lq_agen_csel_pipe_if.slave bus
);
  localparam int unsigned   GRP     = 4;
  localparam logic [NGRP-1:0] RST_VEC = {NGRP{RST_VAL}};

  logic [NGRP-1:0] a_pg;
  logic [NGRP-1:0] a_pt;
  logic            a_glo, a_tlo, a_ghi, a_thi;

  logic            ex3_vld;
  logic            ex3_ci;
  logic            ex3_m32;
  logic [NGRP-1:0] ex3_pg;
  logic [NGRP-1:0] ex3_pt;
  logic            ex3_glo, ex3_tlo, ex3_ghi, ex3_thi;

  logic            b_c4_raw;
  logic            b_c4;
  logic [NGRP-1:0] b_cin;
  logic            b_cout;

  logic            ex4_vld_q;
  logic [NGRP-1:0] ex4_cin_q;
  logic            ex4_cout_q;

  // In-group prefix generate/transmit; each 4-byte group is evaluated as if its carry-in were 0
  always_comb begin
    a_pg = '0;
    a_pt = '0;
    for (int p = 0; p < int'(NGRP); p++) begin
      if ((p % int'(GRP)) == 0) begin
        a_pg[p] = 1'b0;
        a_pt[p] = 1'b1;
      end else begin
        a_pg[p] = bus.ex2_g08[p-1] | (bus.ex2_t08[p-1] & a_pg[p-1]);
        a_pt[p] = bus.ex2_t08[p-1] & a_pt[p-1];
      end
    end
    a_glo = bus.ex2_g08[GRP-1]  | (bus.ex2_t08[GRP-1]  & a_pg[GRP-1]);
    a_tlo = bus.ex2_t08[GRP-1]  & a_pt[GRP-1];
    a_ghi = bus.ex2_g08[NGRP-1] | (bus.ex2_t08[NGRP-1] & a_pg[NGRP-1]);
    a_thi = bus.ex2_t08[NGRP-1] & a_pt[NGRP-1];
  end

  // Valid pipe: flush wins over stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex3_vld   <= 1'b0;
      ex4_vld_q <= 1'b0;
    end else if (bus.flush) begin
      ex3_vld   <= 1'b0;
      ex4_vld_q <= 1'b0;
    end else if (!bus.stall) begin
      ex3_vld   <= bus.ex2_vld;
      ex4_vld_q <= ex3_vld;
    end
  end

  // Stage A data latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex3_ci  <= RST_VAL;
      ex3_m32 <= RST_VAL;
      ex3_pg  <= RST_VEC;
      ex3_pt  <= RST_VEC;
      ex3_glo <= RST_VAL;
      ex3_tlo <= RST_VAL;
      ex3_ghi <= RST_VAL;
      ex3_thi <= RST_VAL;
    end else if (!bus.stall) begin
      ex3_ci  <= bus.ex2_ci;
      ex3_m32 <= bus.ex2_mode32;
      ex3_pg  <= a_pg;
      ex3_pt  <= a_pt;
      ex3_glo <= a_glo;
      ex3_tlo <= a_tlo;
      ex3_ghi <= a_ghi;
      ex3_thi <= a_thi;
    end
  end

  // Stage B: low group driven by ci, high group by the (possibly severed) group carry
  always_comb begin
    b_c4_raw = ex3_glo | (ex3_tlo & ex3_ci);
    b_c4     = b_c4_raw & ~ex3_m32;
    b_cin    = '0;
    for (int p = 0; p < int'(NGRP); p++) begin
      if (p < int'(GRP)) b_cin[p] = ex3_pg[p] | (ex3_pt[p] & ex3_ci);
      else               b_cin[p] = ex3_pg[p] | (ex3_pt[p] & b_c4);
    end
    b_cout = ex3_m32 ? b_c4_raw : (ex3_ghi | (ex3_thi & b_c4));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex4_cin_q  <= RST_VEC;
      ex4_cout_q <= RST_VAL;
    end else if (!bus.stall) begin
      ex4_cin_q  <= b_cin;
      ex4_cout_q <= b_cout;
    end
  end

  assign bus.ex4_vld  = ex4_vld_q;
  assign bus.ex4_cin  = ex4_cin_q;
  assign bus.ex4_cout = ex4_cout_q;

`ifdef LQ_AGEN_CSEL_RIPPLE_CHK_EN
  logic [NGRP-1:0] ex3_g;
  logic [NGRP-1:0] ex3_t;
  logic [NGRP-1:0] r_cin;
  logic            r_cout;
  logic [NGRP-1:0] chk_cin_q;
  logic            chk_cout_q;
  logic            chk_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex3_g <= RST_VEC;
      ex3_t <= RST_VEC;
    end else if (!bus.stall) begin
      ex3_g <= bus.ex2_g08;
      ex3_t <= bus.ex2_t08;
    end
  end

  // Serial ripple reference built only from the raw stage-A operands
  always_comb begin
    r_cin    = '0;
    r_cin[0] = ex3_ci;
    for (int p = 1; p < int'(NGRP); p++)
      r_cin[p] = ex3_g[p-1] | (ex3_t[p-1] & r_cin[p-1]);
    r_cout = ex3_g[NGRP-1] | (ex3_t[NGRP-1] & r_cin[NGRP-1]);
    if (ex3_m32) begin
      r_cout     = r_cin[GRP];
      r_cin[GRP] = 1'b0;
      for (int p = int'(GRP) + 1; p < int'(NGRP); p++)
        r_cin[p] = ex3_g[p-1] | (ex3_t[p-1] & r_cin[p-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_cin_q  <= RST_VEC;
      chk_cout_q <= RST_VAL;
      chk_err_q  <= 1'b0;
    end else begin
      if (!bus.stall) begin
        chk_cin_q  <= r_cin;
        chk_cout_q <= r_cout;
      end
      if (ex4_vld_q && ((ex4_cin_q != chk_cin_q) || (ex4_cout_q != chk_cout_q)))
        chk_err_q <= 1'b1;
    end
  end

  assign bus.chk_err = chk_err_q;
`else
  assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_lq_agen_csel_pipe.sv
// tb_lq_agen_csel_pipe: directed vector table plus stall/flush/reset sequences and a scoreboarded random stream.
module tb_lq_agen_csel_pipe;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  lq_agen_csel_pipe_if bus ();

  lq_agen_csel_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] t;
    logic       ci;
    logic       m32;
    logic [7:0] cin;
    logic       cout;
  } vec_t;

  vec_t          tbl [10];
  logic [8:0]    exp_q [$];

  // Reference: plain byte-serial ripple; bit p of the vectors is byte 7-p
  function automatic logic [8:0] model(input logic [7:0] g, input logic [7:0] t,
                                       input logic ci, input logic m32);
    logic [7:0] c;
    logic       co;
    c    = '0;
    c[0] = ci;
    for (int p = 1; p < 8; p++) c[p] = g[p-1] | (t[p-1] & c[p-1]);
    co = g[7] | (t[7] & c[7]);
    if (m32) begin
      co   = c[4];
      c[4] = 1'b0;
      for (int p = 5; p < 8; p++) c[p] = g[p-1] | (t[p-1] & c[p-1]);
    end
    return {co, c};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] g, input logic [7:0] t,
                       input logic ci, input logic m32, input logic st, input logic fl);
    bus.ex2_vld    = v;
    bus.ex2_g08    = g;
    bus.ex2_t08    = t;
    bus.ex2_ci     = ci;
    bus.ex2_mode32 = m32;
    bus.stall      = st;
    bus.flush      = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [8:0] exp);
    check({name, "_vld"}, 9'(bus.ex4_vld), 9'd1);
    check({name, "_res"}, {bus.ex4_cout, bus.ex4_cin}, exp);
  endtask

  initial begin
    logic [8:0] ra, rb, rc, e;
    logic [7:0] g, t;
    logic       v, ci, m32, st;

    n_vec = 0;
    n_err = 0;

    tbl[0] = '{g: 8'h00, t: 8'hFF, ci: 1'b1, m32: 1'b0, cin: 8'hFF, cout: 1'b1};
    tbl[1] = '{g: 8'h01, t: 8'hFE, ci: 1'b0, m32: 1'b0, cin: 8'hFE, cout: 1'b1};
    tbl[2] = '{g: 8'h01, t: 8'hFE, ci: 1'b0, m32: 1'b1, cin: 8'h0E, cout: 1'b1};
    tbl[3] = '{g: 8'h00, t: 8'hFF, ci: 1'b1, m32: 1'b1, cin: 8'h0F, cout: 1'b1};
    tbl[4] = '{g: 8'h80, t: 8'h00, ci: 1'b0, m32: 1'b0, cin: 8'h00, cout: 1'b1};
    tbl[5] = '{g: 8'h00, t: 8'h00, ci: 1'b1, m32: 1'b0, cin: 8'h01, cout: 1'b0};
    tbl[6] = '{g: 8'h10, t: 8'hFF, ci: 1'b0, m32: 1'b1, cin: 8'hE0, cout: 1'b0};
    tbl[7] = '{g: 8'h08, t: 8'hF7, ci: 1'b0, m32: 1'b0, cin: 8'hF0, cout: 1'b1};
    tbl[8] = '{g: 8'h08, t: 8'hF7, ci: 1'b0, m32: 1'b1, cin: 8'h00, cout: 1'b1};
    tbl[9] = '{g: 8'h00, t: 8'h7F, ci: 1'b1, m32: 1'b0, cin: 8'hFF, cout: 1'b0};

    // Asynchronous reset before any clock edge
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check("rst_vld", 9'(bus.ex4_vld), 9'd0);
    check("rst_res", {bus.ex4_cout, bus.ex4_cin}, 9'd0);
    check("rst_chk", 9'(bus.chk_err), 9'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Directed table: issue, wait one edge, result on ex4 after the second edge
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].g, tbl[i].t, tbl[i].ci, tbl[i].m32, 1'b0, 1'b0);
      step();
      check("tbl_lat1", 9'(bus.ex4_vld), 9'd0);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check_out($sformatf("tbl%0d", i), {tbl[i].cout, tbl[i].cin});
    end
    step();
    check("idle_vld", 9'(bus.ex4_vld), 9'd0);

    // Back-to-back A,B,C with a two-cycle stall after B issues
    ra = {tbl[1].cout, tbl[1].cin};
    rb = {tbl[6].cout, tbl[6].cin};
    rc = {tbl[9].cout, tbl[9].cin};
    drive(1'b1, tbl[1].g, tbl[1].t, tbl[1].ci, tbl[1].m32, 1'b0, 1'b0);
    step();
    drive(1'b1, tbl[6].g, tbl[6].t, tbl[6].ci, tbl[6].m32, 1'b0, 1'b0);
    step();
    check_out("stall_a", ra);
    drive(1'b1, tbl[9].g, tbl[9].t, tbl[9].ci, tbl[9].m32, 1'b1, 1'b0);
    step();
    check_out("stall_hold1", ra);
    step();
    check_out("stall_hold2", ra);
    drive(1'b1, tbl[9].g, tbl[9].t, tbl[9].ci, tbl[9].m32, 1'b0, 1'b0);
    step();
    check_out("stall_b", rb);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("stall_c", rc);
    step();
    check("stall_end", 9'(bus.ex4_vld), 9'd0);

    // Flush kills A in ex3 and drops B issued alongside the flush; C completes
    drive(1'b1, tbl[0].g, tbl[0].t, tbl[0].ci, tbl[0].m32, 1'b0, 1'b0);
    step();
    drive(1'b1, tbl[5].g, tbl[5].t, tbl[5].ci, tbl[5].m32, 1'b0, 1'b1);
    step();
    check("flush_a", 9'(bus.ex4_vld), 9'd0);
    drive(1'b1, tbl[7].g, tbl[7].t, tbl[7].ci, tbl[7].m32, 1'b0, 1'b0);
    step();
    check("flush_b", 9'(bus.ex4_vld), 9'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("flush_c", {tbl[7].cout, tbl[7].cin});
    step();

    // Flush together with stall still clears the valids
    drive(1'b1, tbl[2].g, tbl[2].t, tbl[2].ci, tbl[2].m32, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("fs_pre", {tbl[2].cout, tbl[2].cin});
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("fs_vld", 9'(bus.ex4_vld), 9'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("fs_after", 9'(bus.ex4_vld), 9'd0);

    // Reset while ex3 and ex4 both hold valid ops
    drive(1'b1, tbl[0].g, tbl[0].t, tbl[0].ci, tbl[0].m32, 1'b0, 1'b0);
    step();
    drive(1'b1, tbl[7].g, tbl[7].t, tbl[7].ci, tbl[7].m32, 1'b0, 1'b0);
    step();
    check("prerst_vld", 9'(bus.ex4_vld), 9'd1);
    rst = 1'b1;
    #1;
    check("midrst_vld", 9'(bus.ex4_vld), 9'd0);
    check("midrst_res", {bus.ex4_cout, bus.ex4_cin}, 9'd0);
    step();
    rst = 1'b0;
    drive(1'b1, tbl[4].g, tbl[4].t, tbl[4].ci, tbl[4].m32, 1'b0, 1'b0);
    step();
    check("postrst_e1", 9'(bus.ex4_vld), 9'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("postrst_e2", {tbl[4].cout, tbl[4].cin});
    step();

    // Random stream with random stall; each unstalled edge retires at most one op in order
    for (int i = 0; i < 1000; i++) begin
      v   = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 3) == 0);
      g   = 8'($urandom);
      t   = 8'($urandom);
      ci  = 1'($urandom_range(0, 1));
      m32 = 1'($urandom_range(0, 1));
      drive(v, g, t, ci, m32, st, 1'b0);
      if (v && !st) exp_q.push_back(model(g, t, ci, m32));
      step();
      if (!st && bus.ex4_vld) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 9'd1, 9'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream", {bus.ex4_cout, bus.ex4_cin}, e);
        end
      end
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus.ex4_vld) begin
        if (exp_q.size() == 0) begin
          check("drain_extra", 9'd1, 9'd0);
        end else begin
          e = exp_q.pop_front();
          check("drain", {bus.ex4_cout, bus.ex4_cin}, e);
        end
      end
    end
    check("stream_left", 9'(exp_q.size()), 9'd0);
    check("chk_err_end", 9'(bus.chk_err), 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
